core_cacheop_sched: RTL and testbench

CORE_CACHEOP_SCHED -- requirements
Module: core_cacheop_sched

---
 rtl/core_cacheop_sched_pkg.sv | 26 ++
 rtl/core_cacheop_sched_queue.sv | 46 ++++
 rtl/core_cacheop_sched.sv | 165 ++++++++++++++++
 tb/tb_core_cacheop_sched.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_cacheop_sched_pkg.sv
// Shared cacheop types: op encodings, queue entry and scheduler FSM states.
// The SWEEP state exists only when CACHEOP_SWEEP_EN is defined.
package core_cacheop_sched_pkg;

   typedef enum logic [1:0] {
      OP_IDX_STORE_TAG = 2'b00,
      OP_IDX_INV       = 2'b01,
      OP_HIT_INV       = 2'b10,
      OP_RSVD          = 2'b11
   } cacheop_e;

   typedef struct packed {
      cacheop_e    op;
      logic [31:0] addr;
   } cacheop_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1
`ifdef CACHEOP_SWEEP_EN
      ,
      ST_SWEEP = 2'd2
`endif
   } sched_state_e;

endpackage

// File: rtl/core_cacheop_sched_queue.sv
// Two-entry request FIFO; push while full is accepted only together with a pop.
module cacheop_queue
   import core_cacheop_sched_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     push_i,
   input  cacheop_t data_i,
   input  logic     pop_i,
   output cacheop_t data_o,
   output logic     empty_o,
   output logic     full_o
);

   cacheop_t   mem [2];
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] count;
   logic       push_ok;
   logic       pop_ok;

   assign empty_o = (count == 2'd0);
   assign full_o  = (count == 2'd2);
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);
   assign data_o  = mem[rd_ptr];

   // NOTE: storage is not reset; count gates every read so stale entries are never used.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= data_i;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push_ok) wr_ptr <= ~wr_ptr;
         if (pop_ok)  rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end

endmodule

// File: rtl/core_cacheop_sched.sv
// I-cache cacheop scheduler: queues back-end ops and issues them with valid/ready.
// Optional whole-cache invalidate sweep enabled by defining CACHEOP_SWEEP_EN.
module core_cacheop_sched
   import core_cacheop_sched_pkg::*;
#(
   parameter int SET_NUM    = 256,
   parameter int WAY_NUM    = 2,
   parameter int LINE_BYTES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [1:0]  req_op_i,
   input  logic [31:0] req_addr_i,
   input  logic        sweep_i,
   output logic        cache_valid_o,
   input  logic        cache_ready_i,
   output logic [1:0]  cache_op_o,
   output logic [31:0] cache_addr_o,
   output logic        busy_o,
   output logic        done_o
);

   sched_state_e state_q, state_d;
   cacheop_t     iss_q;
   cacheop_t     req_ent;
   cacheop_t     q_head;
   logic         q_empty;
   logic         q_full;
   logic         q_pop;
   logic         iss_load;

   assign req_ent.op   = cacheop_e'(req_op_i);
   assign req_ent.addr = req_addr_i;
   assign req_ready_o  = !q_full;

   cacheop_queue u_queue (
      .clk     (clk),
      .rst     (rst),
      .push_i  (req_valid_i && req_ready_o),
      .data_i  (req_ent),
      .pop_i   (q_pop),
      .data_o  (q_head),
      .empty_o (q_empty),
      .full_o  (q_full)
   );

`ifdef CACHEOP_SWEEP_EN
   localparam int OFF_W = $clog2(LINE_BYTES);
   localparam int SET_W = $clog2(SET_NUM);
   localparam int WAY_W = $clog2(WAY_NUM);

   logic             sweep_pend_q;
   logic             sweep_start;
   logic             sweep_step;
   logic [SET_W-1:0] set_cnt_q;
   logic [WAY_W-1:0] way_cnt_q;
   logic [31:0]      sweep_addr;
   logic             sweep_last;

   assign sweep_last = (&set_cnt_q) && (&way_cnt_q);

   always_comb begin
      sweep_addr = '0;
      sweep_addr[OFF_W +: SET_W] = set_cnt_q;
      sweep_addr[WAY_W-1:0]      = way_cnt_q;
   end

   // A pulse arriving while a sweep is pending or running is absorbed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sweep_pend_q <= 1'b0;
         set_cnt_q    <= '0;
         way_cnt_q    <= '0;
      end else begin
         if (sweep_start)                          sweep_pend_q <= 1'b0;
         else if (sweep_i && state_q != ST_SWEEP)  sweep_pend_q <= 1'b1;
         if (sweep_step) begin
            way_cnt_q <= way_cnt_q + 1'b1;
            if (&way_cnt_q) set_cnt_q <= set_cnt_q + 1'b1;
         end
      end
   end
`else
   localparam int unused_cfg = SET_NUM + WAY_NUM + LINE_BYTES;
   logic unused_sweep;
   assign unused_sweep = sweep_i;
`endif

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d       = state_q;
      q_pop         = 1'b0;
      iss_load      = 1'b0;
      done_o        = 1'b0;
      cache_valid_o = 1'b0;
      cache_op_o    = OP_IDX_STORE_TAG;
      cache_addr_o  = '0;
`ifdef CACHEOP_SWEEP_EN
      sweep_start   = 1'b0;
      sweep_step    = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
`ifdef CACHEOP_SWEEP_EN
            if (sweep_pend_q) begin
               sweep_start = 1'b1;
               state_d     = ST_SWEEP;
            end else
`endif
            if (!q_empty) begin
               q_pop = 1'b1;
               if (q_head.op == OP_RSVD) begin
                  done_o = 1'b1;
               end else begin
                  iss_load = 1'b1;
                  state_d  = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            cache_valid_o = 1'b1;
            cache_op_o    = iss_q.op;
            cache_addr_o  = iss_q.addr;
            if (cache_ready_i) begin
               done_o  = 1'b1;
               state_d = ST_IDLE;
            end
         end
`ifdef CACHEOP_SWEEP_EN
         ST_SWEEP: begin
            cache_valid_o = 1'b1;
            cache_op_o    = OP_IDX_INV;
            cache_addr_o  = sweep_addr;
            if (cache_ready_i) begin
               sweep_step = 1'b1;
               if (sweep_last) begin
                  done_o  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         iss_q   <= '0;
      end else begin
         state_q <= state_d;
         if (iss_load) iss_q <= q_head;
      end
   end

   assign busy_o = !q_empty || (state_q != ST_IDLE)
`ifdef CACHEOP_SWEEP_EN
                   || sweep_pend_q
`endif
                   ;

endmodule

// File: tb/tb_core_cacheop_sched.sv
// Directed self-checking bench for core_cacheop_sched (sweep tests need CACHEOP_SWEEP_EN).
module tb_core_cacheop_sched;

   logic        clk;
   logic        rst;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [1:0]  req_op_i;
   logic [31:0] req_addr_i;
   logic        sweep_i;
   logic        cache_valid_o;
   logic        cache_ready_i;
   logic [1:0]  cache_op_o;
   logic [31:0] cache_addr_o;
   logic        busy_o;
   logic        done_o;

   int n_cmp;
   int n_err;

   core_cacheop_sched dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .req_op_i      (req_op_i),
      .req_addr_i    (req_addr_i),
      .sweep_i       (sweep_i),
      .cache_valid_o (cache_valid_o),
      .cache_ready_i (cache_ready_i),
      .cache_op_o    (cache_op_o),
      .cache_addr_o  (cache_addr_o),
      .busy_o        (busy_o),
      .done_o        (done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1; req_valid_i = 0; req_op_i = 0; req_addr_i = 0; sweep_i = 0; cache_ready_i = 0;
      #1;
      n_cmp++; if ({req_ready_o, cache_valid_o, cache_op_o, busy_o, done_o} !== 6'b100000) begin
         n_err++; $display("FAIL reset_ctl: got rdy/val/op/busy/done=%b want 100000",
                           {req_ready_o, cache_valid_o, cache_op_o, busy_o, done_o});
      end
      n_cmp++; if (cache_addr_o !== 32'h0) begin
         n_err++; $display("FAIL reset_addr: got %h want 00000000", cache_addr_o);
      end
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single_op();
      @(negedge clk);
      req_valid_i = 1; req_op_i = 2'b10; req_addr_i = 32'h1C00_0040; cache_ready_i = 1;
      #1;
      n_cmp++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b want 1", req_ready_o); end
      @(negedge clk); req_valid_i = 0; #1;
      n_cmp++; if ({cache_valid_o, busy_o, done_o} !== 3'b010) begin
         n_err++; $display("FAIL single_n1: got val/busy/done=%b want 010", {cache_valid_o, busy_o, done_o});
      end
      @(negedge clk); #1;
      n_cmp++; if ({cache_valid_o, cache_op_o, cache_addr_o, done_o} !== {1'b1, 2'b10, 32'h1C00_0040, 1'b1}) begin
         n_err++; $display("FAIL single_n2: got val=%b op=%b addr=%h done=%b want 1 10 1c000040 1",
                           cache_valid_o, cache_op_o, cache_addr_o, done_o);
      end
      @(negedge clk); #1;
      n_cmp++; if ({cache_valid_o, busy_o, done_o} !== 3'b000) begin
         n_err++; $display("FAIL single_after: got val/busy/done=%b want 000", {cache_valid_o, busy_o, done_o});
      end
      cache_ready_i = 0;
   endtask

   task automatic test_backpressure();
      logic [1:0]  ops   [3] = '{2'b00, 2'b01, 2'b10};
      logic [31:0] addrs [3] = '{32'h100, 32'h200, 32'h300};
      int hs = 0, dones = 0;
      cache_ready_i = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         req_valid_i = 1; req_op_i = ops[i]; req_addr_i = addrs[i]; #1;
         n_cmp++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL bp_accept%0d: got ready=%b want 1", i, req_ready_o); end
      end
      @(negedge clk); req_valid_i = 0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_cmp++; if ({req_ready_o, cache_valid_o, cache_op_o, cache_addr_o, done_o} !== {1'b0, 1'b1, ops[0], addrs[0], 1'b0}) begin
            n_err++; $display("FAIL bp_hold%0d: got rdy=%b val=%b op=%b addr=%h done=%b want 0 1 %b %h 0",
                              c, req_ready_o, cache_valid_o, cache_op_o, cache_addr_o, done_o, ops[0], addrs[0]);
         end
         @(negedge clk);
      end
      cache_ready_i = 1;
      for (int c = 0; c < 20 && hs < 3; c++) begin
         #1;
         if (done_o) dones++;
         if (cache_valid_o) begin
            n_cmp++; if ({cache_op_o, cache_addr_o} !== {ops[hs], addrs[hs]}) begin
               n_err++; $display("FAIL bp_order%0d: got op=%b addr=%h want %b %h", hs, cache_op_o, cache_addr_o, ops[hs], addrs[hs]);
            end
            hs++;
         end
         @(negedge clk);
      end
      #1;
      n_cmp++; if ({hs, dones, busy_o} !== {32'd3, 32'd3, 1'b0}) begin
         n_err++; $display("FAIL bp_retire: got hs=%0d done=%0d busy=%b want 3 3 0", hs, dones, busy_o);
      end
      cache_ready_i = 0;
   endtask

   task automatic test_reserved_op();
      @(negedge clk);
      req_valid_i = 1; req_op_i = 2'b11; req_addr_i = 32'hDEAD_BEEF; cache_ready_i = 1;
      @(negedge clk); req_valid_i = 0; #1;
      n_cmp++; if ({cache_valid_o, busy_o, done_o} !== 3'b011) begin
         n_err++; $display("FAIL rsvd_pop: got val/busy/done=%b want 011", {cache_valid_o, busy_o, done_o});
      end
      @(negedge clk); #1;
      n_cmp++; if ({cache_valid_o, busy_o, done_o} !== 3'b000) begin
         n_err++; $display("FAIL rsvd_after: got val/busy/done=%b want 000", {cache_valid_o, busy_o, done_o});
      end
      cache_ready_i = 0;
   endtask

`ifdef CACHEOP_SWEEP_EN
   task automatic test_sweep();
      int k = 0, dones = 0, bad = 0, first_bad = -1;
      logic [31:0] exp_addr;
      @(negedge clk); sweep_i = 1; cache_ready_i = 1;
      @(negedge clk); sweep_i = 0;
      for (int c = 0; c < 700 && dones == 0; c++) begin
         #1;
         if (cache_valid_o) begin
            exp_addr = 32'((k / 2) * 16 + (k % 2));
            if ({cache_op_o, cache_addr_o} !== {2'b01, exp_addr}) begin
               bad++; if (first_bad < 0) first_bad = k;
            end
            if (done_o) begin
               dones++;
               n_cmp++; if (k !== 511) begin n_err++; $display("FAIL sweep_done_at: got hs=%0d want 511", k); end
            end
            k++;
         end
         @(negedge clk);
      end
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL sweep_addr: got %0d bad (first at hs %0d) want 0", bad, first_bad); end
      for (int c = 0; c < 5; c++) begin
         #1; if (cache_valid_o) k++; if (done_o) dones++; @(negedge clk);
      end
      n_cmp++; if ({k, dones, busy_o} !== {32'd512, 32'd1, 1'b0}) begin
         n_err++; $display("FAIL sweep_count: got hs=%0d done=%0d busy=%b want 512 1 0", k, dones, busy_o);
      end
      cache_ready_i = 0;
   endtask

   task automatic test_priority_absorb();
      int hs = 0, dones = 0, sweeps_bad = 0, extra = 0;
      @(negedge clk);
      req_valid_i = 1; req_op_i = 2'b00; req_addr_i = 32'hABCD_0000; sweep_i = 1; cache_ready_i = 1;
      @(negedge clk); req_valid_i = 0; sweep_i = 0;
      for (int c = 0; c < 1200 && hs < 513; c++) begin
         sweep_i = (c == 40 || c == 300);
         #1;
         if (done_o) dones++;
         if (cache_valid_o) begin
            if (hs < 512 && cache_op_o !== 2'b01) sweeps_bad++;
            if (hs == 512) begin
               n_cmp++; if ({cache_op_o, cache_addr_o} !== {2'b00, 32'hABCD_0000}) begin
                  n_err++; $display("FAIL prio_queued: got op=%b addr=%h want 00 abcd0000", cache_op_o, cache_addr_o);
               end
            end
            hs++;
         end
         @(negedge clk);
      end
      sweep_i = 0;
      n_cmp++; if ({hs, sweeps_bad, dones} !== {32'd513, 32'd0, 32'd2}) begin
         n_err++; $display("FAIL prio_seq: got hs=%0d nonsweep=%0d done=%0d want 513 0 2", hs, sweeps_bad, dones);
      end
      for (int c = 0; c < 20; c++) begin
         #1; if (cache_valid_o || done_o) extra++; @(negedge clk);
      end
      n_cmp++; if ({extra, busy_o} !== {32'd0, 1'b0}) begin
         n_err++; $display("FAIL prio_absorb: got extra=%0d busy=%b want 0 0", extra, busy_o);
      end
      cache_ready_i = 0;
   endtask
`else
   task automatic test_sweep_ignored();
      int seen = 0;
      @(negedge clk); sweep_i = 1; cache_ready_i = 1;
      @(negedge clk); sweep_i = 0;
      for (int c = 0; c < 10; c++) begin
         #1; if (cache_valid_o || busy_o || done_o) seen++; @(negedge clk);
      end
      n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL sweep_ignored: got %0d active cycles want 0", seen); end
      cache_ready_i = 0;
   endtask
`endif

   task automatic test_reset_mid_op();
      int seen = 0;
`ifdef CACHEOP_SWEEP_EN
      @(negedge clk); sweep_i = 1; cache_ready_i = 1;
      @(negedge clk); sweep_i = 0;
      repeat (20) @(negedge clk);
`else
      cache_ready_i = 0;
`endif
      req_valid_i = 1; req_op_i = 2'b10; req_addr_i = 32'h0000_5550;
      @(negedge clk); req_valid_i = 0;
      @(negedge clk); #1;
      n_cmp++; if (cache_valid_o !== 1'b1) begin n_err++; $display("FAIL rstmid_active: got val=%b want 1", cache_valid_o); end
      #2 rst = 1'b1; #1;
      n_cmp++; if ({req_ready_o, cache_valid_o, cache_op_o, cache_addr_o, busy_o, done_o} !== {1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL rstmid_out: got rdy=%b val=%b op=%b addr=%h busy=%b done=%b want 1 0 00 0 0 0",
                           req_ready_o, cache_valid_o, cache_op_o, cache_addr_o, busy_o, done_o);
      end
      @(negedge clk); rst = 1'b0; cache_ready_i = 1;
      for (int c = 0; c < 30; c++) begin
         #1; if (cache_valid_o || done_o || busy_o) seen++; @(negedge clk);
      end
      n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL rstmid_discard: got %0d active cycles want 0", seen); end
      cache_ready_i = 0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_single_op();
      test_backpressure();
      test_reserved_op();
`ifdef CACHEOP_SWEEP_EN
      test_sweep();
      test_priority_absorb();
`else
      test_sweep_ignored();
`endif
      test_reset_mid_op();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
